fetch_sequencer: RTL and testbench

- Upstream stage of the instruction ROM. Owns the program counter, drives the ROM address, and registers the returned 28-bit instruction toward decode/execute.
- Applies redirects from the execute stage: JMP/BLE taken, CALL, RET.
- Applies downstream stalls.
- Implements the timed-delay NOP. A NOP with a nonzero 24-bit immediate holds fetch for that many cycles, e.g. the power-up settle delay at address 0.

---
 rtl/fetch_sequencer.sv | 99 +++++++++
 tb/tb_fetch_sequencer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Fetch stage in front of the instruction ROM: owns the PC, registers the fetched word,
// applies execute-stage redirects and downstream stalls, and stretches timed-delay NOPs.
module fetch_sequencer #(
   parameter int         ADDR_W     = 16,
   parameter int         INSTR_W    = 28,
   parameter logic [3:0] NOP_OPCODE = 4'd0,
   parameter int         DELAY_W    = 24
) (
   input  logic               Clock,
   input  logic               Reset,
   output logic [ADDR_W-1:0]  oAddress,
   input  logic [INSTR_W-1:0] iInstruction,
   input  logic               iStall,
   input  logic               iRedirect,
   input  logic [ADDR_W-1:0]  iRedirectTarget,
   output logic [INSTR_W-1:0] oInstruction,
   output logic [ADDR_W-1:0]  oPC,
   output logic               oValid,
   output logic               oBusy
);

   typedef enum logic {ST_FETCH, ST_DELAY} state_t;

   state_t               state_q, state_nxt;
   logic [ADDR_W-1:0]    pc_p0;
   logic [INSTR_W-1:0]   instr_p1;
   logic [ADDR_W-1:0]    pc_p1;
   logic                 vld_p1;
   logic [DELAY_W-1:0]   cnt_q;

   logic [3:0]           opcode;
   logic [DELAY_W-1:0]   imm;
   logic                 delay_nop;

   assign opcode    = iInstruction[INSTR_W-1 -: 4];
   assign imm       = iInstruction[DELAY_W-1:0];
   assign delay_nop = (opcode == NOP_OPCODE) && (imm != '0);

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) state_q <= ST_FETCH;
      else        state_q <= state_nxt;
   end

   always_comb begin
      state_nxt = state_q;
      case (state_q)
         ST_FETCH: if (!iRedirect && !iStall && delay_nop) state_nxt = ST_DELAY;
         ST_DELAY: if (iRedirect || cnt_q == '0)           state_nxt = ST_FETCH;
         default:  state_nxt = ST_FETCH;
      endcase
   end

   // stage p0 (PC / ROM address) -> stage p1 (registered instruction toward decode)
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         pc_p0    <= '0;
         instr_p1 <= '0;
         pc_p1    <= '0;
         vld_p1   <= 1'b0;
         cnt_q    <= '0;
      end else begin
         case (state_q)
            ST_FETCH: begin
               if (iRedirect) begin
                  pc_p0    <= iRedirectTarget;
                  instr_p1 <= '0;
                  vld_p1   <= 1'b0;
               end else if (!iStall) begin
                  instr_p1 <= iInstruction;
                  pc_p1    <= pc_p0;
                  vld_p1   <= 1'b1;
                  pc_p0    <= pc_p0 + 1'b1;
                  if (delay_nop) cnt_q <= imm - 1'b1;
               end
            end
            default: begin
               // Delay ticks ignore iStall; every edge here is a bubble.
               instr_p1 <= '0;
               vld_p1   <= 1'b0;
               if (iRedirect) begin
                  pc_p0 <= iRedirectTarget;
                  cnt_q <= '0;
               end else if (cnt_q != '0) begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
         endcase
      end
   end

   always_comb begin
      oAddress     = pc_p0;
      oInstruction = instr_p1;
      oPC          = pc_p1;
      oValid       = vld_p1;
      oBusy        = (state_q == ST_DELAY);
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a behavioural ROM returns {4'hA,8'h00,addr}
// everywhere except one optional NOP slot whose immediate the tasks choose.
module tb_fetch_sequencer;

   logic        Clock = 1'b0;
   logic        Reset;
   logic [15:0] oAddress;
   logic [27:0] iInstruction;
   logic        iStall;
   logic        iRedirect;
   logic [15:0] iRedirectTarget;
   logic [27:0] oInstruction;
   logic [15:0] oPC;
   logic        oValid;
   logic        oBusy;

   logic        nop_en;
   logic [15:0] nop_addr;
   logic [23:0] nop_imm;

   int total = 0;
   int bad   = 0;
   logic [61:0] exp;
   wire  [61:0] obs = {oValid, oBusy, oPC, oAddress, oInstruction};

   always #5 Clock = ~Clock;

   function automatic logic [27:0] w(input logic [15:0] a);
      return {4'hA, 8'h00, a};
   endfunction

   assign iInstruction = (nop_en && oAddress == nop_addr) ? {4'h0, nop_imm} : w(oAddress);

   fetch_sequencer dut (
      .Clock(Clock), .Reset(Reset), .oAddress(oAddress), .iInstruction(iInstruction),
      .iStall(iStall), .iRedirect(iRedirect), .iRedirectTarget(iRedirectTarget),
      .oInstruction(oInstruction), .oPC(oPC), .oValid(oValid), .oBusy(oBusy)
   );

   task automatic step();
      @(posedge Clock); #1;
   endtask

   task automatic pulse_reset();
      Reset = 1'b0; #2; Reset = 1'b1;
   endtask

   task automatic test_reset();
      Reset = 1'b0; iStall = 0; iRedirect = 0; iRedirectTarget = '0;
      nop_en = 0; nop_addr = '0; nop_imm = '0;
      #1;
      exp = '0; total++;
      if (obs !== exp) begin bad++; $display("FAIL reset_state got=%h want=%h", obs, exp); end
      #1; Reset = 1'b1;
   endtask

   task automatic test_sequential();
      pulse_reset();
      for (int i = 0; i < 4; i++) begin
         step();
         exp = {1'b1, 1'b0, 16'(i), 16'(i + 1), w(16'(i))}; total++;
         if (obs !== exp) begin bad++; $display("FAIL seq_edge%0d got=%h want=%h", i + 1, obs, exp); end
      end
   endtask

   task automatic test_delay_nop();
      nop_en = 1; nop_addr = 16'd0; nop_imm = 24'd4;
      pulse_reset();
      step();
      exp = {1'b1, 1'b1, 16'd0, 16'd1, 4'h0, 24'd4}; total++;
      if (obs !== exp) begin bad++; $display("FAIL nop4_emit got=%h want=%h", obs, exp); end
      for (int i = 0; i < 4; i++) begin
         step();
         exp = {1'b0, (i < 3), 16'd0, 16'd1, 28'd0}; total++;
         if (obs !== exp) begin bad++; $display("FAIL nop4_bubble%0d got=%h want=%h", i, obs, exp); end
      end
      step();
      exp = {1'b1, 1'b0, 16'd1, 16'd2, w(16'd1)}; total++;
      if (obs !== exp) begin bad++; $display("FAIL nop4_resume got=%h want=%h", obs, exp); end
      nop_imm = 24'd0;
      pulse_reset();
      step();
      exp = {1'b1, 1'b0, 16'd0, 16'd1, 28'd0}; total++;
      if (obs !== exp) begin bad++; $display("FAIL nop0_emit got=%h want=%h", obs, exp); end
      step();
      exp = {1'b1, 1'b0, 16'd1, 16'd2, w(16'd1)}; total++;
      if (obs !== exp) begin bad++; $display("FAIL nop0_next got=%h want=%h", obs, exp); end
      nop_en = 0;
   endtask

   task automatic test_stall();
      pulse_reset();
      for (int i = 0; i < 5; i++) step();
      iStall = 1;
      for (int i = 0; i < 3; i++) begin
         step();
         exp = {1'b1, 1'b0, 16'd4, 16'd5, w(16'd4)}; total++;
         if (obs !== exp) begin bad++; $display("FAIL stall_hold%0d got=%h want=%h", i, obs, exp); end
      end
      iStall = 0;
      step();
      exp = {1'b1, 1'b0, 16'd5, 16'd6, w(16'd5)}; total++;
      if (obs !== exp) begin bad++; $display("FAIL stall_resume got=%h want=%h", obs, exp); end
   endtask

   task automatic test_redirect_stall();
      pulse_reset();
      for (int i = 0; i < 20; i++) step();
      iRedirect = 1; iStall = 1; iRedirectTarget = 16'd26;
      step();
      exp = {1'b0, 1'b0, 16'd19, 16'd26, 28'd0}; total++;
      if (obs !== exp) begin bad++; $display("FAIL redir_bubble got=%h want=%h", obs, exp); end
      iRedirect = 0; iStall = 0;
      step();
      exp = {1'b1, 1'b0, 16'd26, 16'd27, w(16'd26)}; total++;
      if (obs !== exp) begin bad++; $display("FAIL redir_target got=%h want=%h", obs, exp); end
      iRedirect = 1; iRedirectTarget = 16'd27;
      step();
      iRedirect = 0;
      step();
      exp = {1'b1, 1'b0, 16'd27, 16'd28, w(16'd27)}; total++;
      if (obs !== exp) begin bad++; $display("FAIL redir_same_pc got=%h want=%h", obs, exp); end
   endtask

   task automatic test_delay_abort();
      nop_en = 1; nop_addr = 16'd0; nop_imm = 24'd5000;
      pulse_reset();
      step();
      for (int i = 0; i < 1999; i++) step();
      exp = {1'b0, 1'b1, 16'd0, 16'd1, 28'd0}; total++;
      if (obs !== exp) begin bad++; $display("FAIL abort_in_delay got=%h want=%h", obs, exp); end
      iRedirect = 1; iRedirectTarget = 16'd10;
      step();
      exp = {1'b0, 1'b0, 16'd0, 16'd10, 28'd0}; total++;
      if (obs !== exp) begin bad++; $display("FAIL abort_redirect got=%h want=%h", obs, exp); end
      iRedirect = 0;
      step();
      exp = {1'b1, 1'b0, 16'd10, 16'd11, w(16'd10)}; total++;
      if (obs !== exp) begin bad++; $display("FAIL abort_fetch got=%h want=%h", obs, exp); end
      pulse_reset();
      step();
      for (int i = 0; i < 10; i++) step();
      Reset = 1'b0; #1;
      exp = '0; total++;
      if (obs !== exp) begin bad++; $display("FAIL reset_mid_delay got=%h want=%h", obs, exp); end
      #1; Reset = 1'b1;
      nop_en = 0;
      step();
      exp = {1'b1, 1'b0, 16'd0, 16'd1, w(16'd0)}; total++;
      if (obs !== exp) begin bad++; $display("FAIL reset_recover got=%h want=%h", obs, exp); end
   endtask

   task automatic test_wrap();
      pulse_reset();
      iRedirect = 1; iRedirectTarget = 16'hFFFF;
      step();
      iRedirect = 0;
      step();
      exp = {1'b1, 1'b0, 16'hFFFF, 16'h0000, w(16'hFFFF)}; total++;
      if (obs !== exp) begin bad++; $display("FAIL wrap_top got=%h want=%h", obs, exp); end
      step();
      exp = {1'b1, 1'b0, 16'h0000, 16'h0001, w(16'h0000)}; total++;
      if (obs !== exp) begin bad++; $display("FAIL wrap_zero got=%h want=%h", obs, exp); end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_delay_nop();
      test_stall();
      test_redirect_stall();
      test_delay_abort();
      test_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
